// File: rtl/fuzz_stim_sequencer_if.sv
// -----------------------------------------------------------------------------
// fuzz_stim_sequencer_if
//
// Purpose: bundles the run-control and DUT-side signals of the fuzz stimulus
// sequencer into one interface.
//
// Parameters:
//   IN_W   DUT input width
//   OUT_W  DUT output width
//   CNT_W  cycle-count width
//
// Signals:
//   start      run-control -> sequencer  one-cycle start pulse
//   abort      run-control -> sequencer  level, forces IDLE
//   seed       run-control -> sequencer  LCG seed (32)
//   cycles     run-control -> sequencer  number of RUN vectors (CNT_W)
//   busy       sequencer -> run-control  high outside IDLE
//   done       sequencer -> run-control  one-cycle completion pulse
//   cyc_count  sequencer -> run-control  RUN vectors issued so far (CNT_W)
//   signature  sequencer -> run-control  MISR result (32)
//   dut_rst_n  sequencer -> DUT          DUT reset, active low
//   dut_in     sequencer -> DUT          stimulus vector (IN_W)
//   dut_out    DUT -> sequencer          DUT response (OUT_W)
//
// Modports: master = run-control / harness side, slave = sequencer.
// -----------------------------------------------------------------------------
interface fuzz_stim_sequencer_if #(
  parameter int IN_W  = 136,
  parameter int OUT_W = 159,
  parameter int CNT_W = 32
);
  logic             start;
  logic             abort;
  logic [31:0]      seed;
  logic [CNT_W-1:0] cycles;
  logic             busy;
  logic             done;
  logic             dut_rst_n;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out;
  logic [CNT_W-1:0] cyc_count;
  logic [31:0]      signature;

  modport master (
    output start, abort, seed, cycles, dut_out,
    input  busy, done, dut_rst_n, dut_in, cyc_count, signature
  );

  modport slave (
    input  start, abort, seed, cycles, dut_out,
    output busy, done, dut_rst_n, dut_in, cyc_count, signature
  );
endinterface

// File: rtl/fuzz_stim_sequencer.sv
// -----------------------------------------------------------------------------
// fuzz_stim_sequencer
//
// Purpose: run controller for the fuzz harness. On start it holds the DUT in
// reset for RST_CYCLES cycles, waits one settle cycle, then drives a fresh
// LCG-derived stimulus vector every cycle for the programmed number of cycles,
// folding the DUT response into a 32-bit MISR signature.
//
// Ports:
//   clk    in  single clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    fuzz_stim_sequencer_if.slave (start/abort/seed/cycles in,
//          busy/done/cyc_count/signature out, dut_rst_n/dut_in out, dut_out in)
//
// Configuration macro: FUZZ_SEQ_MISR_EN
//   defined   -> signature MISR implemented
//   undefined -> signature tied to zero, dut_out unused; timing unchanged
// -----------------------------------------------------------------------------
module fuzz_stim_sequencer #(
  parameter int IN_W       = 136,
  parameter int OUT_W      = 159,
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fuzz_stim_sequencer_if.slave  bus
);

  localparam int          N_WORDS  = (IN_W + 31) / 32;
  localparam int          N_CHUNKS = (OUT_W + 31) / 32;
  localparam int          RC_W     = $clog2(RST_CYCLES + 1);
  localparam logic [31:0] LCG_A    = 32'h41C6_4E6D;
  localparam logic [31:0] LCG_C    = 32'h0000_3039;

  typedef enum logic [2:0] {IDLE, RST, SETTLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             dut_rst_n_reg;
  logic [IN_W-1:0]  dut_in_reg;
  logic [CNT_W-1:0] cyc_count_reg;
  logic [CNT_W-1:0] cycles_reg;
  logic [31:0]      rng_reg;
  logic [RC_W-1:0]  rst_cnt_reg;

  // Vector generation: a chain of LCG steps evaluated in one cycle. The first
  // vector of a run starts from the seed, later ones from the running rng.
  logic [31:0]     chain [0:N_WORDS];
  logic [IN_W-1:0] vec_next;
  logic [31:0]     rng_next;

  assign chain[0] = (state_reg == IDLE) ? bus.seed : rng_reg;
  assign rng_next = chain[N_WORDS];

  generate
    for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_lcg
      assign chain[gi+1] = chain[gi] * LCG_A + LCG_C;
      if (gi < N_WORDS - 1) begin : g_full
        assign vec_next[32*gi +: 32] = chain[gi+1];
      end else begin : g_last
        // Last word only supplies the remaining low bits.
        assign vec_next[IN_W-1:32*gi] = chain[gi+1][IN_W-32*gi-1:0];
      end
    end
  endgenerate

  logic [CNT_W-1:0] cnt_inc;
  assign cnt_inc = cyc_count_reg + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      dut_rst_n_reg <= 1'b0;
      dut_in_reg    <= '0;
      cyc_count_reg <= '0;
      cycles_reg    <= '0;
      rng_reg       <= '0;
      rst_cnt_reg   <= '0;
    end else if (bus.abort) begin
      // Abort wins over every transition; counters and vector freeze.
      state_reg     <= IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      dut_rst_n_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            cycles_reg    <= bus.cycles;
            dut_in_reg    <= vec_next;
            rng_reg       <= rng_next;
            cyc_count_reg <= '0;
            rst_cnt_reg   <= '0;
            busy_reg      <= 1'b1;
            state_reg     <= RST;
          end
        end
        RST: begin
          if (rst_cnt_reg == RC_W'(RST_CYCLES - 1)) begin
            dut_rst_n_reg <= 1'b1;
            state_reg     <= SETTLE;
          end else begin
            rst_cnt_reg <= rst_cnt_reg + RC_W'(1);
          end
        end
        SETTLE: begin
          if (cycles_reg != '0) begin
            state_reg <= RUN;
          end else begin
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        RUN: begin
          dut_in_reg    <= vec_next;
          rng_reg       <= rng_next;
          cyc_count_reg <= cnt_inc;
          // Exit is decided on the incremented value, so the counter never
          // has to reach 2^CNT_W even for the largest legal cycle count.
          if (cnt_inc == cycles_reg) begin
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done_reg      <= 1'b0;
          busy_reg      <= 1'b0;
          dut_rst_n_reg <= 1'b0;
          state_reg     <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef FUZZ_SEQ_MISR_EN
  // Response folding: XOR of all 32-bit chunks of the zero-extended output.
  logic [32*N_CHUNKS-1:0] out_ext;
  logic [31:0]            fold_acc [0:N_CHUNKS];
  logic [31:0]            sig_reg;
  logic [31:0]            sig_next;

  assign out_ext     = (32*N_CHUNKS)'(bus.dut_out);
  assign fold_acc[0] = 32'h0;

  generate
    for (genvar gi = 0; gi < N_CHUNKS; gi++) begin : g_fold
      assign fold_acc[gi+1] = fold_acc[gi] ^ out_ext[32*gi +: 32];
    end
  endgenerate

  assign sig_next = {sig_reg[30:0], sig_reg[31] ^ sig_reg[21] ^ sig_reg[1] ^ sig_reg[0]}
                    ^ fold_acc[N_CHUNKS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_reg <= '0;
    end else if (!bus.abort) begin
      if (state_reg == IDLE && bus.start) begin
        sig_reg <= '0;
      end else if (state_reg == RUN) begin
        sig_reg <= sig_next;
      end
    end
  end

  assign bus.signature = sig_reg;
`else
  logic unused_dut_out;
  assign unused_dut_out = ^bus.dut_out;
  assign bus.signature  = 32'h0;
`endif

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.dut_rst_n = dut_rst_n_reg;
  assign bus.dut_in    = dut_in_reg;
  assign bus.cyc_count = cyc_count_reg;

endmodule

// File: tb/tb_fuzz_stim_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fuzz_stim_sequencer
//
// Purpose: self-checking bench for fuzz_stim_sequencer. A cycle table covers
// the basic seed=0 / cycles=3 run; hand-written sequences cover cycles=0,
// repeatability, abort, start-while-busy and asynchronous reset mid-run.
// Expected vectors and signatures come from an independent LCG/MISR model.
// -----------------------------------------------------------------------------
module tb_fuzz_stim_sequencer;
  localparam int IN_W       = 136;
  localparam int OUT_W      = 159;
  localparam int RST_CYCLES = 2;
  localparam int CNT_W      = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fuzz_stim_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

  fuzz_stim_sequencer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Fixed DUT model: response depends only on the current stimulus.
  function automatic logic [OUT_W-1:0] resp(input logic [IN_W-1:0] v);
    return {~v[22:0], v};
  endfunction

  assign bus.dut_out = resp(bus.dut_in);

  function automatic logic [31:0] lcg(input logic [31:0] r);
    return r * 32'h41C64E6D + 32'h3039;
  endfunction

  task automatic model_vec(input logic [31:0] r_in, output logic [IN_W-1:0] v,
                           output logic [31:0] r_out);
    logic [159:0] w;
    logic [31:0]  r;
    r = r_in;
    w = '0;
    for (int k = 0; k < 5; k++) begin
      r = lcg(r);
      w[32*k +: 32] = r;
    end
    v     = w[IN_W-1:0];
    r_out = r;
  endtask

  function automatic logic [31:0] fold(input logic [OUT_W-1:0] o);
    logic [159:0] e;
    logic [31:0]  f;
    e = {1'b0, o};
    f = '0;
    for (int k = 0; k < 5; k++) f = f ^ e[32*k +: 32];
    return f;
  endfunction

  function automatic logic [31:0] misr(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  task automatic model_run(input logic [31:0] seed, input int cyc,
                           output logic [31:0] sig, output logic [IN_W-1:0] last_v);
    logic [IN_W-1:0] v;
    logic [31:0]     r;
    model_vec(seed, v, r);
    sig = '0;
    for (int i = 0; i < cyc; i++) begin
      sig = misr(sig) ^ fold(resp(v));
      model_vec(r, v, r);
    end
`ifndef FUZZ_SEQ_MISR_EN
    sig = '0;
`endif
    last_v = v;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " busy"},      bus.busy, 0);
    chk({tag, " done"},      bus.done, 0);
    chk({tag, " dut_rst_n"}, bus.dut_rst_n, 0);
    chk({tag, " dut_in"},    bus.dut_in, 0);
    chk({tag, " cyc_count"}, bus.cyc_count, 0);
    chk({tag, " signature"}, bus.signature, 0);
  endtask

  // Starts a run and waits (bounded) for done; returns signature and a hash
  // of every dut_in value seen during the run.
  task automatic run_to_done(input logic [31:0] seed, input int cyc,
                             output logic [31:0] sig, output logic [31:0] hash);
    bit seen;
    seen = 0;
    hash = '0;
    bus.seed = seed; bus.cycles = CNT_W'(cyc); bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < cyc + 20; i++) begin
      hash = {hash[30:0], hash[31]} ^ bus.dut_in[31:0] ^ bus.dut_in[IN_W-1:IN_W-32];
      if (bus.done) begin seen = 1; break; end
      tick();
    end
    chk("run_to_done reached done", seen, 1);
    sig = bus.signature;
    tick();
  endtask

  typedef struct {
    logic        start;
    logic        upd;
    logic        exp_busy;
    logic        exp_done;
    logic        exp_rstn;
    logic [31:0] exp_cnt;
  } row_t;

  row_t tbl [9];

  initial begin
    logic [IN_W-1:0] exp_v, v_hold, last_v;
    logic [31:0]     r, exp_sig, sig1, sig2, h1, h2, sig_frz;
    bit              found, done_seen;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd1};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd2};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'd3};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3};

    bus.start = 1'b0; bus.abort = 1'b0; bus.seed = '0; bus.cycles = '0;
    tick(); tick();
    chk_reset("por");
    rst_n = 1'b1;
    tick();
    chk_reset("idle after release");

    // Table-driven run: seed=0, cycles=3.
    bus.seed = 32'h0; bus.cycles = 3;
    r = 32'h0;
    exp_v = '0;
    for (int i = 0; i < 9; i++) begin
      bus.start = tbl[i].start;
      tick();
      bus.start = 1'b0;
      if (tbl[i].upd) model_vec(r, exp_v, r);
      $display("step %0d busy=%0b done=%0b dut_rst_n=%0b cyc_count=%0d", i,
               bus.busy, bus.done, bus.dut_rst_n, bus.cyc_count);
      chk($sformatf("tbl%0d busy", i),      bus.busy,      tbl[i].exp_busy);
      chk($sformatf("tbl%0d done", i),      bus.done,      tbl[i].exp_done);
      chk($sformatf("tbl%0d dut_rst_n", i), bus.dut_rst_n, tbl[i].exp_rstn);
      chk($sformatf("tbl%0d cyc_count", i), bus.cyc_count, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d dut_in", i),    bus.dut_in,    exp_v);
      if (i == 0) begin
        chk("seed0 word0", bus.dut_in[31:0],  32'h00003039);
        chk("seed0 word1", bus.dut_in[63:32], 32'hD3DC167E);
      end
    end
    model_run(32'h0, 3, exp_sig, last_v);
    chk("seed0 signature", bus.signature, exp_sig);

    // cycles = 0: RST(2) -> SETTLE -> DONE.
    bus.seed = 32'h1234; bus.cycles = 0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    model_vec(32'h1234, exp_v, r);
    v_hold = bus.dut_in;
    chk("c0 first vector", v_hold, exp_v);
    tick(); tick(); tick();
    $display("cycles0 done=%0b cyc_count=%0d", bus.done, bus.cyc_count);
    chk("c0 done", bus.done, 1);
    chk("c0 cyc_count", bus.cyc_count, 0);
    chk("c0 signature", bus.signature, 0);
    chk("c0 dut_in held", bus.dut_in, exp_v);
    tick();
    chk("c0 done drops", bus.done, 0);
    chk("c0 idle busy", bus.busy, 0);

    // Repeatability.
    run_to_done(32'hCAFEF00D, 6, sig1, h1);
    run_to_done(32'hCAFEF00D, 6, sig2, h2);
    model_run(32'hCAFEF00D, 6, exp_sig, last_v);
    $display("repeat sig1=%08h sig2=%08h h1=%08h h2=%08h", sig1, sig2, h1, h2);
    chk("repeat signature equal", sig2, sig1);
    chk("repeat dut_in hash equal", h2, h1);
    chk("repeat signature model", sig1, exp_sig);
    chk("repeat final dut_in", bus.dut_in, last_v);
    chk("repeat cyc_count", bus.cyc_count, 6);

    // Abort during RUN at cyc_count = 2.
    bus.seed = 32'h5; bus.cycles = 10; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.cyc_count == 2) begin found = 1; break; end
      tick();
    end
    chk("abort reach cyc2", found, 1);
    sig_frz = bus.signature;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    $display("abort busy=%0b dut_rst_n=%0b cyc_count=%0d", bus.busy, bus.dut_rst_n, bus.cyc_count);
    chk("abort busy", bus.busy, 0);
    chk("abort dut_rst_n", bus.dut_rst_n, 0);
    chk("abort done", bus.done, 0);
    chk("abort cyc_count", bus.cyc_count, 2);
    chk("abort signature frozen", bus.signature, sig_frz);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) done_seen = 1;
    end
    chk("abort no done", done_seen, 0);
    chk("abort cyc_count holds", bus.cyc_count, 2);
    chk("abort stays idle", bus.busy, 0);

    // Start during RUN is ignored.
    bus.seed = 32'h7; bus.cycles = 4; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.cyc_count == 1) begin found = 1; break; end
      tick();
    end
    chk("busy-start reach run", found, 1);
    bus.seed = 32'd99; bus.cycles = 1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done) begin found = 1; break; end
      tick();
    end
    model_run(32'h7, 4, exp_sig, last_v);
    $display("busy-start done=%0b cyc_count=%0d sig=%08h", bus.done, bus.cyc_count, bus.signature);
    chk("busy-start done seen", found, 1);
    chk("busy-start cyc_count", bus.cyc_count, 4);
    chk("busy-start signature", bus.signature, exp_sig);
    chk("busy-start final dut_in", bus.dut_in, last_v);
    tick();
    bus.seed = 32'h55; bus.cycles = 2; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    model_vec(32'h55, exp_v, r);
    chk("restart cyc_count clear", bus.cyc_count, 0);
    chk("restart signature clear", bus.signature, 0);
    chk("restart dut_in", bus.dut_in, exp_v);
    chk("restart busy", bus.busy, 1);

    // Asynchronous reset in RST.
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset("reset mid-RST");
    #2;
    rst_n = 1'b1;
    tick();
    chk("post-RST-reset idle", bus.busy, 0);
    bus.seed = 32'h9; bus.cycles = 5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("post-RST-reset start accepted", bus.busy, 1);

    // Asynchronous reset in RUN.
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.cyc_count == 1) begin found = 1; break; end
      tick();
    end
    chk("reach run for reset", found, 1);
    rst_n = 1'b0;
    #1;
    chk_reset("reset mid-RUN");
    #2;
    rst_n = 1'b1;
    tick();
    chk("post-RUN-reset idle busy", bus.busy, 0);
    chk("post-RUN-reset dut_rst_n", bus.dut_rst_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fuzz_stim_sequencer.md
Name: fuzz_stim_sequencer

Overview:
- Synthesizable run controller for the fuzz harness.
- Sequences reset of the DUT `top`, then drives `in_flat` with the team's deterministic LCG stream for a programmed number of cycles.
- Compacts `out_flat` into a 32-bit signature.
- Sits between the run-control register file and the DUT, so cross-simulator comparisons need only seed, cycle count and signature.

Parameters:
- IN_W, 136, DUT input width; the vector is built from ceil(IN_W/32) LCG words, and the last word supplies only the low bits needed.
- OUT_W, 159, DUT output width; zero-extended to a multiple of 32 for folding.
- RST_CYCLES, 2, number of clk cycles dut_rst_n is held low per run (>=1).
- CNT_W, 32, width of the cycle-count input and counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; ignored unless the FSM is in IDLE.
- abort  in  1  level; forces IDLE on the next edge, from any state.
- seed  in  32  LCG seed, sampled on accepted start.
- cycles  in  CNT_W  number of RUN vectors, sampled on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a run completes; not asserted on abort.
- dut_rst_n  out  1  DUT reset; low in IDLE and RST, high in SETTLE, RUN and DONE.
- dut_in  out  IN_W  registered stimulus vector.
- dut_out  in  OUT_W  DUT response.
- cyc_count  out  CNT_W  number of RUN vectors issued so far.
- signature  out  32  MISR result; held stable after done until the next start.

Behaviour:
- Reset values: busy=0, done=0, dut_rst_n=0, dut_in=0, cyc_count=0, signature=0, internal rng=0, state=IDLE.
- LCG step: r' = (r*32'h41C64E6D + 32'h3039) mod 2^32.
- A vector is ceil(IN_W/32) chained steps from the current rng:
  - word k fills dut_in[32k+31:32k];
  - the final word contributes r[IN_W-32*(n-1)-1:0];
  - rng is left at the last step's value.
- The chain is combinational within one cycle.
- States: IDLE, RST, SETTLE, RUN, DONE.
- IDLE + start:
  - latch cycles;
  - dut_in <= vector(seed), and rng advances;
  - cyc_count <= 0, signature <= 0;
  - go to RST.
- RST: hold counter counts RST_CYCLES cycles in RST, then go to SETTLE (dut_rst_n rises on that edge).
- SETTLE: lasts exactly one cycle with dut_in unchanged.
  - Go to RUN if latched cycles != 0.
  - Otherwise go to DONE.
- RUN, each cycle:
  - dut_in <= vector(rng), and rng advances;
  - cyc_count++;
  - signature <= {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} XOR fold(dut_out), where fold = XOR of all 32-bit chunks of zero-extended dut_out.
  - The dut_out sampled is the response to the previous vector.
  - Leave to DONE on the edge where cyc_count becomes the latched cycles.
- DONE: done=1 for one cycle, then IDLE.
  - Signature and cyc_count hold their values.
  - dut_in holds its last value.
- abort has priority over every transition: next state is IDLE, dut_rst_n=0, done stays 0, counters and signature freeze.
- start while busy is ignored; start and abort together in IDLE: abort wins, stay IDLE.
- cyc_count cannot wrap: the exit compare happens before the increment reaches 2^CNT_W.
- cycles = 2^CNT_W-1 is legal.
- rst_n asserted mid-run resets all outputs immediately (asynchronous), including dut_rst_n=0.

Optional Feature:
- Macro FUZZ_SEQ_MISR_EN.
- Defined: the signature MISR is implemented as above.
- Undefined: no MISR logic; signature is tied to 32'h0 and dut_out is unused. All other timing is identical.

Test Plan:
- seed=0, cycles=3, start pulse:
  - next edge: dut_in[31:0]=32'h00003039, dut_in[63:32]=32'hD3DC167E;
  - busy=1, dut_rst_n=0 for 2 cycles, then 1;
  - done pulses exactly 1 cycle after 3 RUN cycles, with cyc_count=3.
- cycles=0: RST(2) -> SETTLE -> DONE; done after 4 cycles with cyc_count=0, signature=0, dut_in unchanged from start.
- Same seed and cycles run twice with dut_out driven from a fixed model: identical dut_in sequence and identical signature both runs. With the macro undefined, signature is 0.
- abort asserted during RUN at cyc_count=2: next edge state IDLE, busy=0, dut_rst_n=0, done never pulses, cyc_count holds 2.
- start pulsed during RUN: ignored, and the run completes with the original cycles value. Then start in IDLE with a new seed: signature and cyc_count clear on that edge.
- rst_n low mid-RST and mid-RUN: all outputs are at reset values before the next clk edge; after release the FSM is in IDLE.
